// File: rtl/s713_state_capture_if.sv
// s713_state_capture_if
//   Bundles the data and control signals that pass between the s713 cone bank
//   (or a bench standing in for it) and the state-capture back end.
//   Signals:
//     ns_in    [N] next-state vector from the combinational cones
//     start        single-cycle run request
//     misr_clr     reload the signature to its seed
//     scan_en      manual shift enable
//     scan_in      serial data into the state register LSB
//     state_q  [N] current state register (fed back to the cones)
//     scan_out     state register MSB
//     sig      [N] MISR signature
//     busy         capture or unload in progress
//     done         one-cycle pulse when the unload finishes
//   Modports: master drives the requests and data; slave is the capture block.
interface s713_state_capture_if #(
  parameter int N = 19
);
  logic [N-1:0] ns_in;
  logic         start;
  logic         misr_clr;
  logic         scan_en;
  logic         scan_in;
  logic [N-1:0] state_q;
  logic         scan_out;
  logic [N-1:0] sig;
  logic         busy;
  logic         done;

  modport master (
    output ns_in, start, misr_clr, scan_en, scan_in,
    input  state_q, scan_out, sig, busy, done
  );

  modport slave (
    input  ns_in, start, misr_clr, scan_en, scan_in,
    output state_q, scan_out, sig, busy, done
  );
endinterface

// File: rtl/s713_state_capture.sv
// s713_state_capture
//   Sequential back end for the s713 combinational partial-output cones.
//   A run captures CAP_CYCLES next-state vectors into the state register
//   (the first on the start edge itself), folds every captured vector into a
//   MISR signature, then shifts the state out MSB-first over N cycles.
//   While idle the state register can be shifted manually and the MISR can be
//   reloaded to SEED.
//   Ports:
//     CK   clock, all flops on the rising edge
//     RST  asynchronous active-high reset
//     bus  s713_state_capture_if.slave (ns_in/start/misr_clr/scan_en/scan_in in,
//          state_q/scan_out/sig/busy/done out)
module s713_state_capture #(
  parameter int           N          = 19,
  parameter int           CAP_CYCLES = 8,
  parameter logic [N-1:0] POLY       = 19'h00027,
  parameter logic [N-1:0] SEED       = 19'h00001
) (
  input logic                  CK,
  input logic                  RST,
  s713_state_capture_if.slave  bus
);

  localparam int CAP_W = $clog2(CAP_CYCLES);
  localparam int N_W   = $clog2(N);
  localparam int CW    = ((CAP_W > N_W) ? CAP_W : N_W) + 1;

  // The start edge is capture #1, so CAPTURE itself performs CAP_CYCLES-1
  // captures, counted 0..CAP_CYCLES-2.
  localparam logic [CW-1:0] CAP_LAST = CW'((CAP_CYCLES > 1) ? (CAP_CYCLES - 2) : 0);
  localparam logic [CW-1:0] UNL_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    UNLOAD  = 2'd2
  } fsm_t;

  fsm_t          fsm_reg;
  logic [CW-1:0] cnt_reg;
  logic [N-1:0]  state_reg;
  logic [N-1:0]  sig_reg;
  logic          busy_reg;
  logic          done_reg;

  logic [N-1:0]  misr_next;
  logic [N-1:0]  shift_next;

  // MISR step: shift left, fold the outgoing MSB back through the tap mask,
  // then XOR in the captured vector.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_misr
      if (gi == 0) begin : g_lsb
        assign misr_next[gi] = (sig_reg[N-1] & POLY[gi]) ^ bus.ns_in[gi];
      end else begin : g_bit
        assign misr_next[gi] = sig_reg[gi-1] ^ (sig_reg[N-1] & POLY[gi]) ^ bus.ns_in[gi];
      end
    end
  endgenerate

  assign shift_next = {state_reg[N-2:0], bus.scan_in};

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      fsm_reg   <= IDLE;
      cnt_reg   <= '0;
      state_reg <= '0;
      sig_reg   <= SEED;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (fsm_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg <= bus.ns_in;
            sig_reg   <= misr_next;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            // With a single capture the start edge already completes the
            // capture phase.
            fsm_reg   <= (CAP_CYCLES == 1) ? UNLOAD : CAPTURE;
          end else if (bus.scan_en) begin
            state_reg <= shift_next;
          end else if (bus.misr_clr) begin
            sig_reg <= SEED;
          end
        end

        CAPTURE: begin
          state_reg <= bus.ns_in;
          sig_reg   <= misr_next;
          if (cnt_reg == CAP_LAST) begin
            fsm_reg <= UNLOAD;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        UNLOAD: begin
          state_reg <= shift_next;
          if (cnt_reg == UNL_LAST) begin
            fsm_reg  <= IDLE;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        default: begin
          fsm_reg  <= IDLE;
          cnt_reg  <= '0;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state_q  = state_reg;
  assign bus.scan_out = state_reg[N-1];
  assign bus.sig      = sig_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;

endmodule

// File: tb/tb_s713_state_capture.sv
// tb_s713_state_capture
//   Randomised bench for s713_state_capture with a behavioural model
//   (run phase tracked as remaining captures / remaining shifts, MISR as
//   polynomial multiply-by-x modulo P plus the captured vector) and a
//   negedge compare process, plus literal expectations for the scripted runs.
module tb_s713_state_capture;

  localparam int           N          = 19;
  localparam int           CAP_CYCLES = 8;
  localparam logic [N-1:0] POLY       = 19'h00027;
  localparam logic [N-1:0] SEED       = 19'h00001;

  logic CK;
  logic RST;
  bit   ck_run;
  bit   chk_on;

  int n_checks;
  int n_fail;

  s713_state_capture_if #(.N(N)) bus ();

  s713_state_capture #(
    .N(N), .CAP_CYCLES(CAP_CYCLES), .POLY(POLY), .SEED(SEED)
  ) dut (
    .CK (CK),
    .RST(RST),
    .bus(bus)
  );

  initial begin
    CK = 1'b0;
    forever begin
      #5;
      if (ck_run) CK = ~CK;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Signature as a GF(2) polynomial: multiply by x, reduce by P = x^N + POLY,
  // add the captured vector.
  function automatic logic [N-1:0] misr_model(input logic [N-1:0] s, input logic [N-1:0] d);
    logic [N:0] t;
    t = {s, 1'b0};
    if (t[N]) t = t ^ {1'b1, POLY};
    return t[N-1:0] ^ d;
  endfunction

  logic [N-1:0] m_state;
  logic [N-1:0] m_sig;
  int           m_caps;    // captures still to take after this point
  int           m_shifts;  // unload shifts still to perform
  logic         m_done;

  always @(posedge CK or posedge RST) begin
    if (RST) begin
      m_state  = '0;
      m_sig    = SEED;
      m_caps   = 0;
      m_shifts = 0;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_caps > 0) begin
        m_state = bus.ns_in;
        m_sig   = misr_model(m_sig, bus.ns_in);
        m_caps  = m_caps - 1;
        if (m_caps == 0) m_shifts = N;
      end else if (m_shifts > 0) begin
        m_state  = {m_state[N-2:0], bus.scan_in};
        m_shifts = m_shifts - 1;
        if (m_shifts == 0) m_done = 1'b1;
      end else if (bus.start) begin
        m_state = bus.ns_in;
        m_sig   = misr_model(m_sig, bus.ns_in);
        m_caps  = CAP_CYCLES - 1;
        if (m_caps == 0) m_shifts = N;
      end else if (bus.scan_en) begin
        m_state = {m_state[N-2:0], bus.scan_in};
      end else if (bus.misr_clr) begin
        m_sig = SEED;
      end
    end
  end

  always @(negedge CK) begin
    if (chk_on) begin
      chk("cmp_state_q",  32'(bus.state_q),  32'(m_state));
      chk("cmp_sig",      32'(bus.sig),      32'(m_sig));
      chk("cmp_scan_out", 32'(bus.scan_out), 32'(m_state[N-1]));
      chk("cmp_busy",     32'(bus.busy),     32'((m_caps > 0) || (m_shifts > 0)));
      chk("cmp_done",     32'(bus.done),     32'(m_done));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge CK);
    #2;
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.misr_clr = 1'b0;
    bus.scan_en  = 1'b0;
    bus.scan_in  = 1'b0;
  endtask

  task automatic check_reset_now(input string tag);
    chk({tag, "_state_q"},  32'(bus.state_q),  32'h0);
    chk({tag, "_sig"},      32'(bus.sig),      32'h00001);
    chk({tag, "_busy"},     32'(bus.busy),     32'h0);
    chk({tag, "_done"},     32'(bus.done),     32'h0);
    chk({tag, "_scan_out"}, 32'(bus.scan_out), 32'h0);
  endtask

  // One run: start with first_ns, then rest_ns (or random traffic when rnd).
  task automatic run(input bit rnd, input logic [N-1:0] first_ns, input logic [N-1:0] rest_ns,
                     output logic [N-1:0] first_state, output int busy_cyc,
                     output int dones, output logic [N-1:0] unl_seq);
    int guard;
    busy_cyc = 0;
    dones    = 0;
    unl_seq  = '0;
    guard    = 0;
    idle_inputs();
    bus.start = 1'b1;
    bus.ns_in = first_ns;
    cyc();
    first_state = bus.state_q;
    bus.start = 1'b0;
    bus.ns_in = rest_ns;
    while (bus.busy === 1'b1 && guard < 200) begin
      busy_cyc++;
      guard++;
      if (m_shifts > 0) unl_seq = {unl_seq[N-2:0], bus.scan_out};
      if (rnd) begin
        bus.ns_in    = N'($urandom);
        bus.start    = ($urandom_range(0, 3) == 0);
        bus.misr_clr = ($urandom_range(0, 2) == 0);
        bus.scan_en  = ($urandom_range(0, 2) == 0);
        bus.scan_in  = 1'($urandom);
      end
      cyc();
      if (bus.done === 1'b1) dones++;
    end
    if (guard >= 200) bound_fail("run_wait");
    idle_inputs();
  endtask

  logic [N-1:0] first_state;
  logic [N-1:0] unl_seq;
  logic [N-1:0] pat;
  logic [N-1:0] exp_sig;
  int           busy_cyc;
  int           dones;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ck_run   = 1'b0;
    chk_on   = 1'b0;
    RST      = 1'b0;
    bus.ns_in = '0;
    idle_inputs();

    // Asynchronous reset with the clock stopped.
    #3;
    RST = 1'b1;
    #1;
    check_reset_now("reset_async");

    ck_run = 1'b1;
    cyc();
    cyc();
    RST = 1'b0;
    chk_on = 1'b1;
    cyc();

    // Single run, ns_in held at 1: state 1 after start edge, busy for
    // (CAP_CYCLES-1) capture cycles + N unload cycles = 26, MSB-first unload
    // gives 18 zeros then a one, exactly one done.
    run(1'b0, 19'h00001, 19'h00001, first_state, busy_cyc, dones, unl_seq);
    $display("run single: first_state=%05h busy=%0d dones=%0d unload=%05h", first_state, busy_cyc, dones, unl_seq);
    chk("single_first_state", 32'(first_state), 32'h00001);
    chk("single_busy_cycles", 32'(busy_cyc), 32'd26);
    chk("single_unload_seq",  32'(unl_seq), 32'h00001);
    chk("single_done_count",  32'(dones), 32'd1);
    cyc();

    // MISR golden: reload seed, capture 7FFFF then seven zeros.
    bus.misr_clr = 1'b1;
    cyc();
    bus.misr_clr = 1'b0;
    chk("misr_clr_seed", 32'(bus.sig), 32'h00001);
    run(1'b0, 19'h7FFFF, 19'h00000, first_state, busy_cyc, dones, unl_seq);
    $display("run misr golden: sig=%05h dones=%0d", bus.sig, dones);
    chk("misr_golden_sig", 32'(bus.sig), 32'h7F01D);
    chk("misr_golden_done", 32'(dones), 32'd1);

    // Second run continues from the golden signature (no clear).
    run(1'b0, N'($urandom), N'($urandom), first_state, busy_cyc, dones, unl_seq);
    $display("run misr continue: sig=%05h model=%05h", bus.sig, m_sig);
    chk("misr_continue_sig", 32'(bus.sig), 32'(m_sig));

    // Manual scan of 5A5A5, MSB first.
    pat = 19'h5A5A5;
    for (int i = 0; i < N; i++) begin
      bus.scan_en = 1'b1;
      bus.scan_in = pat[N-1-i];
      cyc();
    end
    idle_inputs();
    $display("manual scan: state_q=%05h", bus.state_q);
    chk("manual_scan_state", 32'(bus.state_q), 32'h5A5A5);

    // misr_clr loses to scan_en.
    exp_sig = m_sig;
    bus.scan_en  = 1'b1;
    bus.misr_clr = 1'b1;
    cyc();
    idle_inputs();
    $display("misr_clr with scan_en: sig=%05h", bus.sig);
    chk("misr_clr_scan_hold", 32'(bus.sig), 32'(exp_sig));
    chk("misr_clr_scan_shift", 32'(bus.state_q), 32'h34B4A);

    // Requests during a run are ignored.
    run(1'b1, N'($urandom), N'($urandom), first_state, busy_cyc, dones, unl_seq);
    $display("run with noise: busy=%0d dones=%0d", busy_cyc, dones);
    chk("noise_busy_cycles", 32'(busy_cyc), 32'd26);
    chk("noise_done_count",  32'(dones), 32'd1);
    cyc();

    // Abort on the 5th UNLOAD cycle.
    begin
      int guard;
      int ab_dones;
      guard = 0;
      ab_dones = 0;
      bus.start = 1'b1;
      bus.ns_in = N'($urandom);
      cyc();
      bus.start = 1'b0;
      while (m_shifts != N - 4 && guard < 100) begin
        bus.ns_in   = N'($urandom);
        bus.scan_in = 1'($urandom);
        cyc();
        guard++;
        if (bus.done === 1'b1) ab_dones++;
      end
      if (guard >= 100) bound_fail("abort_wait");
      RST = 1'b1;
      #1;
      check_reset_now("abort");
      cyc();
      if (bus.done === 1'b1) ab_dones++;
      cyc();
      if (bus.done === 1'b1) ab_dones++;
      RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
        cyc();
        if (bus.done === 1'b1) ab_dones++;
      end
      $display("abort: dones=%0d", ab_dones);
      chk("abort_no_done", 32'(ab_dones), 32'd0);
    end

    run(1'b0, N'($urandom), N'($urandom), first_state, busy_cyc, dones, unl_seq);
    $display("run after abort: busy=%0d dones=%0d", busy_cyc, dones);
    chk("post_abort_busy", 32'(busy_cyc), 32'd26);
    chk("post_abort_done", 32'(dones), 32'd1);

    // Random soak; every cycle is checked against the model.
    for (int i = 0; i < 400; i++) begin
      bus.ns_in    = N'($urandom);
      bus.start    = ($urandom_range(0, 15) == 0);
      bus.scan_en  = ($urandom_range(0, 2) == 0);
      bus.misr_clr = ($urandom_range(0, 3) == 0);
      bus.scan_in  = 1'($urandom);
      cyc();
    end
    idle_inputs();
    cyc();
    $display("soak: state_q=%05h sig=%05h", bus.state_q, bus.sig);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
